// File: rtl/viterbi_pkg.sv
// ----------------------------------------------------------------------------
// viterbi_pkg
// Definitions shared by the K=3 convolutional encoder and the Viterbi
// decoder: default generator polynomials, the shift-register state encoding
// and the encoder control-FSM type.
//
// Build option: TAIL_FLUSH_EN adds the TAIL state used for zero-tail flushing.
// ----------------------------------------------------------------------------
package viterbi_pkg;

    // Generator polynomials, taps ordered {b, sr[1], sr[0]}
    localparam logic [2:0] G0_DEFAULT = 3'b111;
    localparam logic [2:0] G1_DEFAULT = 3'b101;

    // Shift-register state encoding {sr[1], sr[0]}, shared with the decoder
    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_10 = 2'b10;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;

    // Encoder control states
`ifdef TAIL_FLUSH_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } enc_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } enc_state_t;
`endif

endpackage

// File: rtl/conv_branch_out.sv
// ----------------------------------------------------------------------------
// conv_branch_out
// Combinational branch-output function of the rate-1/2, K=3 code. The decoder
// instantiates the same block to label its trellis branches.
//
// Ports:
//   b    in  1  input bit for this branch
//   sr   in  2  current shift-register state {sr[1], sr[0]}
//   sym  out 2  code symbol {c0, c1}
// ----------------------------------------------------------------------------
module conv_branch_out
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0 = G0_DEFAULT,
    parameter logic [2:0] G1 = G1_DEFAULT
) (
    input  logic       b,
    input  logic [1:0] sr,
    output logic [1:0] sym
);

    logic [2:0] taps;

    assign taps   = {b, sr};
    assign sym[1] = ^(G0 & taps);
    assign sym[0] = ^(G1 & taps);

endmodule

// File: rtl/conv_enc_k3.sv
// ----------------------------------------------------------------------------
// conv_enc_k3
// Rate-1/2, K=3 convolutional encoder with ready/valid handshakes on both
// sides and a one-deep registered output.
//
// Build option: TAIL_FLUSH_EN
//   defined   : after the i_last bit, two zero tail bits are encoded and the
//               second tail symbol carries o_last (N bits -> N+2 symbols).
//   undefined : o_last rides on the i_last bit's symbol and the shift register
//               is cleared right after it (N bits -> N symbols).
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous reset, active low
//   i_bit    in   1      information bit
//   i_valid  in   1      qualifies i_bit / i_last
//   i_last   in   1      final information bit of the frame
//   o_ready  out  1      encoder accepts i_bit this cycle
//   o_sym    out  2      code symbol {c0, c1}
//   o_valid  out  1      qualifies o_sym / o_last
//   i_ready  in   1      downstream accepts o_sym this cycle
//   o_last   out  1      final symbol of the frame
//   o_st     out  2      current shift-register state
//   o_cnt    out  CNT_W  symbols emitted in the current frame (saturating)
// ----------------------------------------------------------------------------
module conv_enc_k3
    import viterbi_pkg::*;
#(
    parameter logic [2:0]  G0    = G0_DEFAULT,
    parameter logic [2:0]  G1    = G1_DEFAULT,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bit,
    input  logic             i_valid,
    input  logic             i_last,
    output logic             o_ready,
    output logic [1:0]       o_sym,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic [1:0]       o_st,
    output logic [CNT_W-1:0] o_cnt
);

    enc_state_t state, state_next;
    logic [1:0] sr;
    logic [1:0] sym;
    logic       out_free;
    logic       in_xfer;
    logic       load;
    logic       load_b;
    logic       load_last;
    logic       first_sym;
`ifdef TAIL_FLUSH_EN
    logic       tail_second;
    logic       tail_load;
`endif

    // The output register can take a new symbol when empty or being drained.
    assign out_free = !o_valid || i_ready;

`ifdef TAIL_FLUSH_EN
    assign o_ready   = out_free && (state != TAIL);
    assign tail_load = out_free && (state == TAIL);
`else
    assign o_ready   = out_free;
`endif

    assign in_xfer = i_valid && o_ready;
    assign o_st    = sr;

    conv_branch_out #(
        .G0 (G0),
        .G1 (G1)
    ) u_branch (
        .b   (load_b),
        .sr  (sr),
        .sym (sym)
    );

    // Decide what (if anything) is loaded into the output register this cycle
    // and where the control FSM goes next.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_b     = 1'b0;
        load_last  = 1'b0;
        first_sym  = 1'b0;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    load      = 1'b1;
                    load_b    = i_bit;
                    first_sym = 1'b1;
`ifdef TAIL_FLUSH_EN
                    state_next = i_last ? TAIL : RUN;
`else
                    load_last  = i_last;
                    state_next = i_last ? IDLE : RUN;
`endif
                end
            end
            RUN: begin
                if (in_xfer) begin
                    load   = 1'b1;
                    load_b = i_bit;
`ifdef TAIL_FLUSH_EN
                    if (i_last) state_next = TAIL;
`else
                    load_last = i_last;
                    if (i_last) state_next = IDLE;
`endif
                end
            end
`ifdef TAIL_FLUSH_EN
            TAIL: begin
                if (tail_load) begin
                    load = 1'b1;
                    if (tail_second) begin
                        load_last  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

`ifdef TAIL_FLUSH_EN
    // Tracks which of the two tail bits is next; it toggles back to zero
    // after the second one so the next frame starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           tail_second <= 1'b0;
        else if (tail_load) tail_second <= !tail_second;
    end
`endif

    // Shift register; the frame-final load always returns it to zero state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= ST_00;
        end else if (load) begin
            if (load_last) sr <= ST_00;
            else           sr <= {load_b, sr[1]};
        end
    end

    // Output register: loads a new symbol, or empties once consumed, and
    // otherwise holds its contents while downstream stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sym   <= 2'b00;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else if (load) begin
            o_sym   <= sym;
            o_valid <= 1'b1;
            o_last  <= load_last;
        end else if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end
    end

    // Per-frame symbol counter; restarts at 1 on a frame's first symbol,
    // saturates, and holds its final value between frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_cnt <= '0;
        end else if (load) begin
            if (first_sym)              o_cnt <= CNT_W'(1);
            else if (o_cnt != '1)       o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_conv_enc_k3.sv
// ----------------------------------------------------------------------------
// tb_conv_enc_k3
// Self-checking bench for conv_enc_k3. Expected symbols come from a direct
// convolution of each frame's bit sequence with the generator polynomials.
// Honours TAIL_FLUSH_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_conv_enc_k3;
    import viterbi_pkg::*;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             i_bit;
    logic             i_valid;
    logic             i_last;
    logic             o_ready;
    logic [1:0]       o_sym;
    logic             o_valid;
    logic             i_ready;
    logic             o_last;
    logic [1:0]       o_st;
    logic [CNT_W-1:0] o_cnt;

    typedef struct {
        logic [1:0] sym;
        logic       last;
        int         cnt;
    } exp_t;

    bit         frame_bits[$];
    exp_t       exp_q[$];
    int         frame_total;
    int         checks   = 0;
    int         failures = 0;
    logic [2:0] g0_ref   = 3'b111;
    logic [2:0] g1_ref   = 3'b101;

    conv_enc_k3 #(
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_bit   (i_bit),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_sym   (o_sym),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last),
        .o_st    (o_st),
        .o_cnt   (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: each symbol is the parity of the generator taps over the
    // current and two previous frame bits (zero before the frame starts).
    task automatic buildExpected();
        bit   seq[$];
        exp_t e;
        seq = frame_bits;
`ifdef TAIL_FLUSH_EN
        seq.push_back(1'b0);
        seq.push_back(1'b0);
`endif
        exp_q.delete();
        for (int k = 0; k < seq.size(); k++) begin
            int p0 = 0;
            int p1 = 0;
            for (int j = 0; j < 3; j++) begin
                bit u;
                u = 1'b0;
                if (k - j >= 0) u = seq[k - j];
                if (u && g0_ref[2 - j]) p0++;
                if (u && g1_ref[2 - j]) p1++;
            end
            e.sym  = {p0[0], p1[0]};
            e.last = (k == seq.size() - 1);
            e.cnt  = (k + 1 > CNT_MAX) ? CNT_MAX : k + 1;
            exp_q.push_back(e);
        end
        frame_total = (seq.size() > CNT_MAX) ? CNT_MAX : seq.size();
    endtask

    // Drives frame_bits through the encoder and checks every presented
    // symbol. mode 0: always ready; 1: random ready/valid; 2: 3-cycle stall
    // while the second symbol is presented.
    task automatic applyStimulus(input int mode);
        int n;
        int bit_idx;
        int cycles;
        int limit;
        int sym_seen;
        int stall_left;
        bit stalled;
        buildExpected();
        n          = frame_bits.size();
        bit_idx    = 0;
        cycles     = 0;
        sym_seen   = 0;
        stall_left = 0;
        stalled    = 1'b0;
        limit      = 20 * n + 100;
        while ((bit_idx < n || exp_q.size() > 0) && cycles < limit) begin
            @(negedge clk);
            if (mode == 2 && o_valid && sym_seen == 1 && !stalled) begin
                stall_left = 3;
                stalled    = 1'b1;
            end
            if (mode == 1)      i_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) i_ready = (stall_left == 0);
            else                i_ready = 1'b1;
            if (stall_left > 0) stall_left--;
            if (bit_idx < n) begin
                i_valid = (mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
                i_bit   = frame_bits[bit_idx];
                i_last  = (bit_idx == n - 1);
            end else begin
                i_valid = 1'b0;
                i_bit   = 1'($urandom_range(0, 1));
                i_last  = 1'b0;
            end
            #1;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_sym", 32'(o_valid), 32'd0);
                end else begin
                    checkOutput("sym",  32'(o_sym),  32'(exp_q[0].sym));
                    checkOutput("last", 32'(o_last), 32'(exp_q[0].last));
                    checkOutput("cnt",  32'(o_cnt),  32'(exp_q[0].cnt));
                end
                if (!i_ready) checkOutput("stall_ready", 32'(o_ready), 32'd0);
            end
            if (o_valid && i_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                sym_seen++;
            end
            if (i_valid && o_ready) bit_idx++;
            cycles++;
        end
        checkOutput("timeout", 32'(cycles >= limit), 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        #1;
        checkOutput("end_valid", 32'(o_valid), 32'd0);
        checkOutput("end_st",    32'(o_st),    32'(ST_00));
        checkOutput("end_cnt",   32'(o_cnt),   32'(frame_total));
        exp_q.delete();
    endtask

    initial begin
        rst     = 1'b0;
        i_bit   = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;

        // Reset state before any clock edge
        #2;
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_sym",   32'(o_sym),   32'd0);
        checkOutput("rst_last",  32'(o_last),  32'd0);
        checkOutput("rst_cnt",   32'(o_cnt),   32'd0);
        checkOutput("rst_st",    32'(o_st),    32'(ST_00));
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Directed frame 1,0,1,1 with downstream always ready
        $display("[TB] frame 1011");
        frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(0);

        // Same frame with a 3-cycle downstream stall on the second symbol
        $display("[TB] frame 1011 with stall");
        applyStimulus(2);

        // Reset pulsed mid-frame after two accepted bits
        $display("[TB] mid-frame reset");
        @(negedge clk);
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_bit   = 1'b1;
        i_last  = 1'b0;
        @(negedge clk);
        i_bit = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        checkOutput("pre_rst_cnt", 32'(o_cnt), 32'd2);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(o_valid), 32'd0);
        checkOutput("mid_rst_sym",   32'(o_sym),   32'd0);
        checkOutput("mid_rst_last",  32'(o_last),  32'd0);
        checkOutput("mid_rst_cnt",   32'(o_cnt),   32'd0);
        checkOutput("mid_rst_st",    32'(o_st),    32'(ST_00));
        checkOutput("mid_rst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        applyStimulus(0);

        // Single-bit frame
        $display("[TB] single-bit frame");
        frame_bits = '{1'b1};
        applyStimulus(0);

        // Random frames with random handshakes
        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, 20);
            frame_bits.delete();
            for (int i = 0; i < len; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
            applyStimulus(1);
        end

        // Long frame drives the symbol counter into saturation
        $display("[TB] 300-bit frame");
        frame_bits.delete();
        for (int i = 0; i < 300; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
        applyStimulus(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
